// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures one retiring instruction per cycle into a record FIFO
// and streams records to the trace sink over valid/ready, counting retired/dropped commits.
module commit_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       commit_valid,
    input  logic [XLEN-1:0]            commit_pc,
    input  logic [31:0]                commit_instr,
    input  logic                       rf_we,
    input  logic [4:0]                 rf_rd,
    input  logic [XLEN-1:0]            rf_wdata,
    input  logic                       dm_we,
    input  logic [XLEN-1:0]            dm_addr,
    input  logic [XLEN-1:0]            dm_wdata,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [XLEN-1:0]            trace_pc,
    output logic [31:0]                trace_instr,
    output logic                       trace_rd_we,
    output logic [4:0]                 trace_rd,
    output logic [XLEN-1:0]            trace_rd_data,
    output logic                       trace_mem_we,
    output logic [XLEN-1:0]            trace_mem_addr,
    output logic [XLEN-1:0]            trace_mem_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       overflow,
    output logic [CNT_W-1:0]           retire_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            rd_we;
        logic [4:0]      rd;
        logic [XLEN-1:0] rd_data;
        logic            mem_we;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
    } rec_t;

    rec_t          mem [DEPTH];
    rec_t          wrec;
    rec_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop, drop;

    // x0 writes are not architectural; unused fields are zeroed so records compare cleanly
    always_comb begin
        wrec          = '0;
        wrec.pc       = commit_pc;
        wrec.instr    = commit_instr;
        wrec.rd_we    = rf_we && (rf_rd != 5'd0);
        wrec.rd       = wrec.rd_we ? rf_rd : 5'd0;
        wrec.rd_data  = wrec.rd_we ? rf_wdata : '0;
        wrec.mem_we   = dm_we;
        wrec.mem_addr = dm_we ? dm_addr : '0;
        wrec.mem_data = dm_we ? dm_wdata : '0;
    end

    assign full        = (level == LW'(DEPTH));
    assign trace_valid = (level != '0);
    assign pop         = trace_valid && trace_ready;
    assign push        = commit_valid && (!full || pop);
    assign drop        = commit_valid && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            overflow     <= 1'b0;
            retire_count <= '0;
            drop_count   <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wrec;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (commit_valid) retire_count <= retire_count + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

    // show-ahead: head entry drives the trace port straight from storage
    assign head           = mem[rd_ptr];
    assign trace_pc       = head.pc;
    assign trace_instr    = head.instr;
    assign trace_rd_we    = head.rd_we;
    assign trace_rd       = head.rd;
    assign trace_rd_data  = head.rd_data;
    assign trace_mem_we   = head.mem_we;
    assign trace_mem_addr = head.mem_addr;
    assign trace_mem_data = head.mem_data;
endmodule
